// File: rtl/y86_mem_arbiter.sv
// Shared single-port memory arbiter for the Y86-64 pipeline: serves the memory stage
// (one 64-bit beat) ahead of the fetch stage (two beats), with range checking and bus timeout.
module y86_mem_arbiter #(
    parameter logic [63:0] MEM_TOP = 64'h0000_0000_0000_1FFF,
    parameter int          TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    // fetch stage
    input  logic        f_req,
    input  logic [63:0] f_addr,
    output logic        f_done,
    output logic [79:0] f_instr,
    output logic        f_err,
    // memory stage
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_done,
    output logic [63:0] d_rdata,
    output logic        d_err,
    // stall requests to pipeline control
    output logic        f_stall_req,
    output logic        m_stall_req,
    // memory bus
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_D_ACC = 3'd1,
        ST_F_B0  = 3'd2,
        ST_F_B1  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    // True when an access of span+1 bytes starting at addr would touch a byte above
    // MEM_TOP; the extra bit makes a wrap past 2^64 count as out of range.
    function automatic logic range_err(input logic [63:0] addr, input logic [64:0] span);
        return (({1'b0, addr} + span) > {1'b0, MEM_TOP});
    endfunction

    state_t      state_r;
    logic [63:0] beat0_r;
    logic [7:0]  cnt_r;

    logic        d_range_err_s;
    logic        f_range_err_s;
    logic [7:0]  cnt_inc_s;
    logic        timeout_s;

    assign d_range_err_s = range_err(d_addr, 65'd7);
    assign f_range_err_s = range_err(f_addr, 65'd9);
    assign cnt_inc_s     = cnt_r + 8'd1;
    assign timeout_s     = (cnt_inc_s == TIMEOUT_C);

    assign f_stall_req = f_req & ~f_done;
    assign m_stall_req = d_req & ~d_done;

    // Arbitration FSM; all bus and response outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 64'd0;
            mem_wdata <= 64'd0;
            f_done    <= 1'b0;
            f_err     <= 1'b0;
            f_instr   <= 80'd0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= 64'd0;
            beat0_r   <= 64'd0;
            cnt_r     <= 8'd0;
        end else begin
            // done/err are single-cycle pulses raised only on the transition into RESP
            f_done <= 1'b0;
            f_err  <= 1'b0;
            d_done <= 1'b0;
            d_err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (d_req) begin
                        if (d_range_err_s) begin
                            state_r <= ST_RESP;
                            d_done  <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= 64'd0;
                        end else begin
                            state_r   <= ST_D_ACC;
                            mem_req   <= 1'b1;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            cnt_r     <= 8'd0;
                        end
                    end else if (f_req) begin
                        if (f_range_err_s) begin
                            state_r <= ST_RESP;
                            f_done  <= 1'b1;
                            f_err   <= 1'b1;
                            f_instr <= 80'd0;
                        end else begin
                            state_r  <= ST_F_B0;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= f_addr;
                            cnt_r    <= 8'd0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_D_ACC: begin
                    if (mem_ready) begin
                        state_r <= ST_RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        d_done  <= 1'b1;
                        d_rdata <= mem_we ? 64'd0 : mem_rdata;
                    end else if (timeout_s) begin
                        state_r <= ST_RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        d_done  <= 1'b1;
                        d_err   <= 1'b1;
                        d_rdata <= 64'd0;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_F_B0: begin
                    if (mem_ready) begin
                        state_r  <= ST_F_B1;
                        beat0_r  <= mem_rdata;
                        mem_addr <= mem_addr + 64'd8;
                        cnt_r    <= 8'd0;
                    end else if (timeout_s) begin
                        state_r <= ST_RESP;
                        mem_req <= 1'b0;
                        f_done  <= 1'b1;
                        f_err   <= 1'b1;
                        f_instr <= 80'd0;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_F_B1: begin
                    if (mem_ready) begin
                        state_r <= ST_RESP;
                        mem_req <= 1'b0;
                        f_done  <= 1'b1;
                        f_instr <= {mem_rdata[15:0], beat0_r};
                    end else if (timeout_s) begin
                        state_r <= ST_RESP;
                        mem_req <= 1'b0;
                        f_done  <= 1'b1;
                        f_err   <= 1'b1;
                        f_instr <= 80'd0;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Directed bench for y86_mem_arbiter: a vector table of single accesses plus hand-written
// sequences for arbitration order, fetch locking and reset during a fetch.
module tb_y86_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, d_req, d_we;
    logic [63:0] f_addr, d_addr, d_wdata;
    logic        f_done, f_err, d_done, d_err;
    logic [79:0] f_instr;
    logic [63:0] d_rdata;
    logic        f_stall_req, m_stall_req;
    logic        mem_req, mem_we, mem_ready;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model state
    int          wait_cfg = 0;
    int          wcnt = 0;
    int          bus_cycles = 0;
    logic [63:0] wr_addr_seen = 64'd0;
    logic [63:0] wr_data_seen = 64'd0;

    y86_mem_arbiter #(.MEM_TOP(64'h1FFF), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_instr(f_instr), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .f_stall_req(f_stall_req), .m_stall_req(m_stall_req),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Memory contents: a few fixed words, otherwise {~addr[31:0], addr[31:0]}.
    always_comb begin
        case (mem_addr)
            64'h100: mem_rdata = 64'h1122_3344_5566_7788;
            64'h20:  mem_rdata = 64'h0807_0605_0403_0201;
            64'h28:  mem_rdata = 64'hDEAD_BEEF_CAFE_0A09;
            default: mem_rdata = {~mem_addr[31:0], mem_addr[31:0]};
        endcase
    end

    // wait_cfg wait states per beat; 255 means the bus never answers
    assign mem_ready = mem_req && (wait_cfg != 255) && (wcnt >= wait_cfg);

    always @(posedge clk) begin
        if (mem_req) bus_cycles <= bus_cycles + 1;
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (mem_req && mem_ready && mem_we) begin
            wr_addr_seen <= mem_addr;
            wr_data_seen <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          wait_c;
        logic        exp_err;
        logic [79:0] exp_data;
        int          exp_lat;
        int          exp_bus;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic run_vec(input vec_t v);
        int   n;
        int   bus0;
        logic got;
        wait_cfg = v.wait_c;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            f_req = 1'b1; f_addr = v.addr;
        end
        #1;
        check({v.name, "_stall"}, {79'd0, v.is_d ? m_stall_req : f_stall_req}, 80'd1);
        bus0 = bus_cycles;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            got = v.is_d ? d_done : f_done;
        end
        check({v.name, "_latency"}, 80'(n), 80'(v.exp_lat));
        check({v.name, "_err"}, {79'd0, v.is_d ? d_err : f_err}, {79'd0, v.exp_err});
        check({v.name, "_data"}, v.is_d ? {16'd0, d_rdata} : f_instr, v.exp_data);
        check({v.name, "_bus_cycles"}, 80'(bus_cycles - bus0), 80'(v.exp_bus));
        f_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        @(posedge clk); #1;
        check({v.name, "_done_pulse"}, {78'd0, f_done, d_done}, 80'd0);
    endtask

    initial begin
        int d_cyc;
        int f_cyc;

        //          is_d  we    addr                    wdata                  wt   err   data                              lat bus
        vecs[0]  = '{1'b1, 1'b0, 64'h100,                64'h0,                 0,   1'b0, 80'h1122_3344_5566_7788,          2,  1,  "d_rd"};
        vecs[1]  = '{1'b1, 1'b1, 64'h200,                64'hA5A5_0F0F_1234_5678, 0, 1'b0, 80'h0,                            2,  1,  "d_wr"};
        vecs[2]  = '{1'b1, 1'b0, 64'h300,                64'h0,                 3,   1'b0, 80'hFFFF_FCFF_0000_0300,          5,  4,  "d_rd_wait3"};
        vecs[3]  = '{1'b0, 1'b0, 64'h20,                 64'h0,                 0,   1'b0, 80'h0A09_0807_0605_0403_0201,     3,  2,  "f_plain"};
        vecs[4]  = '{1'b0, 1'b0, 64'h40,                 64'h0,                 2,   1'b0, 80'h0048_FFFF_FFBF_0000_0040,     7,  6,  "f_wait2"};
        vecs[5]  = '{1'b1, 1'b0, 64'h1FFA,               64'h0,                 0,   1'b1, 80'h0,                            1,  0,  "d_range"};
        vecs[6]  = '{1'b1, 1'b0, 64'h1FF8,               64'h0,                 0,   1'b0, 80'hFFFF_E007_0000_1FF8,          2,  1,  "d_top_ok"};
        vecs[7]  = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,                0,   1'b1, 80'h0,                            1,  0,  "f_wrap"};
        vecs[8]  = '{1'b0, 1'b0, 64'h1FF6,               64'h0,                 0,   1'b0, 80'h1FFE_FFFF_E009_0000_1FF6,     3,  2,  "f_top_ok"};
        vecs[9]  = '{1'b0, 1'b0, 64'h1FF7,               64'h0,                 0,   1'b1, 80'h0,                            1,  0,  "f_range"};
        vecs[10] = '{1'b1, 1'b0, 64'h400,                64'h0,                 255, 1'b1, 80'h0,                            17, 16, "d_timeout"};
        vecs[11] = '{1'b0, 1'b0, 64'h500,                64'h0,                 255, 1'b1, 80'h0,                            17, 16, "f_timeout"};

        rst_n = 1'b0;
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = 64'd0; d_addr = 64'd0; d_wdata = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", {79'd0, mem_req}, 80'd0);
        check("rst_dones", {76'd0, f_done, d_done, f_err, d_err}, 80'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 80'd0);
        f_req = 1'b1;
        #1;
        check("rst_f_stall", {79'd0, f_stall_req}, 80'd1);
        f_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        check("wr_addr", {16'd0, wr_addr_seen}, {16'd0, 64'h200});
        check("wr_data", {16'd0, wr_data_seen}, {16'd0, 64'hA5A5_0F0F_1234_5678});

        // both requests at cycle 0: data first, fetch restarts from IDLE
        wait_cfg = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
        f_req = 1'b1; f_addr = 64'h20;
        d_cyc = -1; f_cyc = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) check("both_c1_addr", {16'd0, mem_addr}, {16'd0, 64'h100});
            if (d_done) begin
                d_cyc = c;
                check("both_d_rdata", {16'd0, d_rdata}, {16'd0, 64'h1122_3344_5566_7788});
                d_req = 1'b0;
            end
            if (f_done) begin
                f_cyc = c;
                check("both_f_instr", f_instr, 80'h0A09_0807_0605_0403_0201);
                f_req = 1'b0;
            end
        end
        check("both_d_cycle", 80'(d_cyc), 80'd2);
        check("both_f_cycle", 80'(f_cyc), 80'd6);

        // data request raised during a fetch waits for the fetch to finish
        f_req = 1'b1; f_addr = 64'h20;
        d_cyc = -1; f_cyc = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                check("lock_c1_addr", {16'd0, mem_addr}, {16'd0, 64'h20});
                d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
            end
            if (c == 2) check("lock_c2_addr", {16'd0, mem_addr}, {16'd0, 64'h28});
            if (d_done) begin
                d_cyc = c;
                d_req = 1'b0;
            end
            if (f_done) begin
                f_cyc = c;
                f_req = 1'b0;
            end
        end
        check("lock_f_cycle", 80'(f_cyc), 80'd3);
        check("lock_d_cycle", 80'(d_cyc), 80'd6);

        // reset in F_B1 abandons the fetch and clears every registered output
        f_req = 1'b1; f_addr = 64'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstmid_b1_addr", {16'd0, mem_addr}, {16'd0, 64'h48});
        rst_n = 1'b0;
        #1;
        check("rstmid_mem_req", {79'd0, mem_req}, 80'd0);
        check("rstmid_mem_addr", {16'd0, mem_addr}, 80'd0);
        check("rstmid_f_instr", f_instr, 80'd0);
        check("rstmid_d_rdata", {16'd0, d_rdata}, 80'd0);
        check("rstmid_f_stall", {79'd0, f_stall_req}, 80'd1);
        f_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000 ns");
        $fatal(1);
    end

endmodule

// File: doc/y86_mem_arbiter.md
# y86_mem_arbiter

Arbitrates one shared single-port memory between the Y86-64 pipeline's fetch stage (instruction read, 10 bytes) and memory stage (data read/write, 8 bytes). A fetch is sequenced as two 64-bit bus beats; a data access is one beat. The block enforces a bus-response timeout and address-range check, and returns stall requests that the pipeline control unit ORs into its fetch/memory stall terms.

## Interface
- `MEM_TOP`, default 64'h0000_0000_0000_1FFF: highest legal byte address; any access touching a byte above it errors.
- `TIMEOUT`, default 16: max cycles `mem_req` may wait for `mem_ready` (range 1..255).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `f_req`  in  1  fetch request; held with `f_addr` stable until `f_done`.
- `f_addr`  in  64  fetch byte address (PC).
- `f_done`  out  1  one-cycle pulse: `f_instr`/`f_err` valid.
- `f_instr`  out  80  instruction bytes; byte k at [8k+7:8k]; held until next `f_done`.
- `f_err`  out  1  fetch address error, valid with `f_done`.
- `d_req`  in  1  data request; held with `d_we`/`d_addr`/`d_wdata` stable until `d_done`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  64  data byte address.
- `d_wdata`  in  64  write data.
- `d_done`  out  1  one-cycle pulse: `d_rdata`/`d_err` valid.
- `d_rdata`  out  64  read data (0 for writes and errors); held until next `d_done`.
- `d_err`  out  1  data address error/timeout, valid with `d_done`.
- `f_stall_req`  out  1  `f_req & ~f_done` (combinational).
- `m_stall_req`  out  1  `d_req & ~d_done` (combinational).
- `mem_req`  out  1  bus request; high for the entire access state.
- `mem_we`  out  1  bus write enable.
- `mem_addr`  out  64  bus byte address; memory returns bytes addr..addr+7 little-endian.
- `mem_wdata`  out  64  bus write data.
- `mem_rdata`  in  64  bus read data, valid with `mem_ready`.
- `mem_ready`  in  1  bus completion; may assert in the same cycle as `mem_req`.

## Operation
- States: IDLE, D_ACC, F_B0, F_B1, RESP.
- IDLE arbitration at each edge: `d_req` wins over `f_req` (the memory-stage instruction is older).
  - `d_req` with range error: go to RESP with `d_err` pending; no bus access.
  - `d_req` otherwise: go to D_ACC.
  - else `f_req` with range error: go to RESP with `f_err` pending; no bus access.
  - `f_req` otherwise: go to F_B0.
- Range error: data if `d_addr > MEM_TOP-7`; fetch if `f_addr > MEM_TOP-9`. Compare in 65-bit arithmetic so address wrap-around counts as an error.
- D_ACC: `mem_addr=d_addr`, `mem_we=d_we`, `mem_wdata=d_wdata`. On `mem_ready`, capture `mem_rdata` (reads only) and go to RESP.
- F_B0: `mem_addr=f_addr`, `mem_we=0`. On `mem_ready`, latch beat0 and go to F_B1.
- F_B1: `mem_addr=f_addr+8`. On `mem_ready`, `f_instr={mem_rdata[15:0], beat0}` and go to RESP.
- A fetch is locked: a `d_req` arriving during F_B0/F_B1 waits until the fetch finishes.
- RESP: pulse the pending `*_done` (plus `*_err`) for exactly one cycle, then return to IDLE. No new request is accepted in RESP, so the next arbitration happens in IDLE.
- Timeout: an 8-bit counter clears on entry to each access state and increments each cycle without `mem_ready`. When it reaches `TIMEOUT` (no ready), drop `mem_req` and go to RESP with err=1 and data 0. A fetch timing out in F_B0 skips F_B1.
- Requester dropping `req` mid-access is illegal; the access completes and `done` still pulses.

## Timing
- Zero-wait memory, request seen in IDLE at cycle 0:
  - Data: D_ACC at cycle 1, `d_done` at cycle 2.
  - Fetch: beats at cycles 1 and 2, `f_done` at cycle 3.
  - Range error: `done` at cycle 1.
- Each wait state adds one cycle per beat.
- Reset (any time, any state): state=IDLE. `mem_req`, `mem_we`, `f_done`, `d_done`, `f_err`, `d_err` = 0. `mem_addr`, `mem_wdata`, `f_instr`, `d_rdata`, beat0, counter = 0. An in-flight bus access is abandoned.
- Stall outputs follow the inputs combinationally, including during reset.

## Test plan
- Data read, `d_addr`=0x100, memory returns 0x1122334455667788 with zero wait -> `d_done` at cycle 2, `d_rdata`=0x1122334455667788, `d_err`=0; `m_stall_req` high in cycles 0–1.
- Fetch, `f_addr`=0x20, beat0=0x0807060504030201, beat1 low half=0x0A09 -> `mem_addr` 0x20 then 0x28; `f_instr`=0x0A090807060504030201 at cycle 3.
- `d_req` and `f_req` both asserted at cycle 0 -> data served first (`d_done` cycle 2); fetch starts from IDLE at cycle 3 and gives `f_done` at cycle 6. A `d_req` raised at cycle 1 of a fetch waits for `f_done`.
- `d_addr`=0x1FFA (MEM_TOP=0x1FFF) and `f_addr`=0xFFFF_FFFF_FFFF_FFFC -> `*_done` with err=1 one cycle after IDLE; `mem_req` never rises.
- `mem_ready` held low, TIMEOUT=16 -> `mem_req` high for 16 cycles, then `d_done` with `d_err`=1 and `d_rdata`=0.
- Assert `rst_n`=0 during F_B1 -> all outputs 0 immediately; after release, a fresh `f_req` completes normally.
